// File: rtl/paddle_motion_ctrl_pkg.sv
// Shared paddle/screen definitions: FSM state encodings, default screen geometry
// and a pixel-in-square helper reused by the ball and carpet blocks.
package paddle_motion_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } paddle_state_e;

    localparam int DEF_SPAWN_COL  = 300;
    localparam int DEF_SPAWN_ROW  = 399;
    localparam int DEF_LEFT_EDGE  = 47;
    localparam int DEF_RIGHT_EDGE = 584;
    localparam int DEF_SIZE       = 8;

    // 17-bit sums so a sprite near the top of the 16-bit range cannot wrap.
    function automatic logic in_square(input logic [15:0] px,
                                       input logic [15:0] py,
                                       input logic [15:0] ox,
                                       input logic [15:0] oy,
                                       input logic [16:0] size);
        logic [16:0] x_end;
        logic [16:0] y_end;
        x_end = {1'b0, ox} + size;
        y_end = {1'b0, oy} + size;
        return (px >= ox) && ({1'b0, px} < x_end) &&
               (py >= oy) && ({1'b0, py} < y_end);
    endfunction

endpackage

// File: rtl/paddle_motion_ctrl_pb_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a counter debouncer.
// The output follows the input only after DEBOUNCE_CYCLES consecutive differing samples.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_raw,
    output logic pb_db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any sample equal to the accepted value restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pb_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pb_db = db_q;

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Per-frame paddle sequencer: spawn/track/lost FSM, position registers, respawn
// frame counter and the registered pixel-hit flag for the colour mux.
module paddle_motion_ctrl
    import paddle_motion_ctrl_pkg::*;
#(
    parameter int SPAWN_COL       = DEF_SPAWN_COL,
    parameter int SPAWN_ROW       = DEF_SPAWN_ROW,
    parameter int LEFT_EDGE       = DEF_LEFT_EDGE,
    parameter int RIGHT_EDGE      = DEF_RIGHT_EDGE,
    parameter int STEP            = 1,
    parameter int SIZE            = DEF_SIZE,
    parameter int RESPAWN_FRAMES  = 60,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        pb0,
    input  logic [15:0] col,
    input  logic [15:0] row,
    output logic [15:0] paddle_col,
    output logic [15:0] paddle_row,
    output logic        paddle,
    output logic        lost,
    output logic [1:0]  state_dbg
);

    localparam int FW = $clog2(RESPAWN_FRAMES + 1);

    paddle_state_e state_q, state_d;
    logic [15:0]   paddle_col_q, paddle_col_d;
    logic [15:0]   paddle_row_q, paddle_row_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          paddle_q, paddle_d;
    logic          lost_q, lost_d;
    logic          pb_db;
    logic [15:0]   step_col;

    pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb_debounce (
        .clk   (clk),
        .reset (reset),
        .pb_raw(pb0),
        .pb_db (pb_db)
    );

    // Moving left saturates at column 0 instead of wrapping.
    always_comb begin
        if (pb_db) begin
            step_col = paddle_col_q + 16'(STEP);
        end else if (paddle_col_q >= 16'(STEP)) begin
            step_col = paddle_col_q - 16'(STEP);
        end else begin
            step_col = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        paddle_col_d = paddle_col_q;
        paddle_row_d = paddle_row_q;
        fcnt_d       = fcnt_q;
        lost_d       = 1'b0;
        paddle_d     = (state_q != ST_LOST) &&
                       in_square(col, row, paddle_col_q, paddle_row_q, 17'(SIZE));
        if (frame_tick) begin
            unique case (state_q)
                ST_SPAWN: begin
                    paddle_col_d = 16'(SPAWN_COL);
                    paddle_row_d = 16'(SPAWN_ROW);
                    state_d      = ST_TRACK;
                end
                ST_TRACK: begin
                    paddle_col_d = step_col;
                    if (step_col <= 16'(LEFT_EDGE) || step_col >= 16'(RIGHT_EDGE)) begin
                        state_d = ST_LOST;
                        lost_d  = 1'b1;
                    end
                end
                ST_LOST: begin
                    if (fcnt_q == FW'(RESPAWN_FRAMES - 1)) begin
                        fcnt_d  = '0;
                        state_d = ST_SPAWN;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_SPAWN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SPAWN;
            paddle_col_q <= 16'(SPAWN_COL);
            paddle_row_q <= 16'(SPAWN_ROW);
            fcnt_q       <= '0;
            paddle_q     <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddle_col_q <= paddle_col_d;
            paddle_row_q <= paddle_row_d;
            fcnt_q       <= fcnt_d;
            paddle_q     <= paddle_d;
            lost_q       <= lost_d;
        end
    end

    assign paddle_col = paddle_col_q;
    assign paddle_row = paddle_row_q;
    assign paddle     = paddle_q;
    assign lost       = lost_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// Self-checking bench for paddle_motion_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural frame-level model.
module tb_paddle_motion_ctrl;

    localparam int DEB     = 4;
    localparam int RESPAWN = 3;
    localparam int M_SPAWN = 0;
    localparam int M_TRACK = 1;
    localparam int M_LOST  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        pb0 = 1'b0;
    logic [15:0] col = '0;
    logic [15:0] row = '0;
    logic [15:0] paddle_col;
    logic [15:0] paddle_row;
    logic        paddle;
    logic        lost;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: plain integers, one update per clock edge.
    int m_state = M_SPAWN;
    int m_col = 300;
    int m_row = 399;
    int m_fcnt = 0;
    int m_paddle = 0;
    int m_lost = 0;
    int m_db = 0;
    int m_prev_s = 0;
    int m_run = 0;
    int raw_q[$] = '{0, 0};

    paddle_motion_ctrl #(
        .RESPAWN_FRAMES (RESPAWN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_tick(frame_tick),
        .pb0       (pb0),
        .col       (col),
        .row       (row),
        .paddle_col(paddle_col),
        .paddle_row(paddle_row),
        .paddle    (paddle),
        .lost      (lost),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        int s;
        int nc;
        if (reset) begin
            m_state = M_SPAWN; m_col = 300; m_row = 399; m_fcnt = 0;
            m_paddle = 0; m_lost = 0; m_db = 0; m_prev_s = 0; m_run = 0;
            raw_q = '{0, 0};
        end else begin
            m_paddle = (m_state != M_LOST) && (col >= m_col) && (col < m_col + 8) &&
                       (row >= m_row) && (row < m_row + 8);
            m_lost = 0;
            if (frame_tick) begin
                case (m_state)
                    M_SPAWN: begin m_col = 300; m_row = 399; m_state = M_TRACK; end
                    M_TRACK: begin
                        nc = (m_db != 0) ? m_col + 1 : ((m_col > 0) ? m_col - 1 : 0);
                        m_col = nc;
                        if (nc <= 47 || nc >= 584) begin m_state = M_LOST; m_lost = 1; end
                    end
                    default: begin
                        if (m_fcnt == RESPAWN - 1) begin m_fcnt = 0; m_state = M_SPAWN; end
                        else m_fcnt++;
                    end
                endcase
            end
            // Button seen two clocks late; accepted after DEB equal differing samples.
            s = raw_q.pop_front();
            raw_q.push_back(int'(pb0));
            m_run = (s == m_prev_s) ? m_run + 1 : 1;
            m_prev_s = s;
            if (m_run >= DEB && s != m_db) m_db = s;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs at a falling edge, then wait n falling edges.
    task automatic applyStimulus(input logic pb, input logic tick, input int c, input int r, input int n);
        pb0 = pb;
        frame_tick = tick;
        col = 16'(c);
        row = 16'(r);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_state", 32'(state_dbg), 32'(m_state));
            checkOutput("model_col", 32'(paddle_col), 32'(m_col));
            checkOutput("model_row", 32'(paddle_row), 32'(m_row));
            checkOutput("model_paddle", 32'(paddle), 32'(m_paddle));
            checkOutput("model_lost", 32'(lost), 32'(m_lost));
        end
    end

    initial begin
        logic pb_r;
        @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst_col", 32'(paddle_col), 300);
        checkOutput("rst_row", 32'(paddle_row), 399);
        checkOutput("rst_paddle", 32'(paddle), 0);
        checkOutput("rst_lost", 32'(lost), 0);
        checkOutput("rst_state", 32'(state_dbg), 0);
        reset = 1'b0;

        // Hold right, then SPAWN tick plus four steps.
        applyStimulus(1, 0, 0, 0, 8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 0, 1);
            applyStimulus(1, 0, 0, 0, 1);
        end
        checkOutput("right_col", 32'(paddle_col), 304);
        checkOutput("right_row", 32'(paddle_row), 399);

        // Release, then a short glitch that must not be accepted.
        applyStimulus(0, 0, 0, 0, 8);
        applyStimulus(1, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 8);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("glitch_col", 32'(paddle_col), 303);

        // Walk down to 48, then the tick that reaches the left edge.
        applyStimulus(0, 1, 0, 0, 255);
        checkOutput("pre_edge_col", 32'(paddle_col), 48);
        checkOutput("pre_edge_state", 32'(state_dbg), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("edge_col", 32'(paddle_col), 47);
        checkOutput("edge_state", 32'(state_dbg), 2);
        checkOutput("edge_lost", 32'(lost), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("lost_pulse_end", 32'(lost), 0);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("lost_hold", 32'(state_dbg), 2);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("respawn_state", 32'(state_dbg), 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("respawn_track", 32'(state_dbg), 1);
        checkOutput("respawn_col", 32'(paddle_col), 300);

        // Pixel hit boundaries around (300,399).
        applyStimulus(0, 0, 300, 399, 1);
        checkOutput("hit_corner", 32'(paddle), 1);
        applyStimulus(0, 0, 308, 399, 1);
        checkOutput("hit_right_out", 32'(paddle), 0);
        applyStimulus(0, 0, 307, 406, 1);
        checkOutput("hit_far_corner", 32'(paddle), 1);
        applyStimulus(0, 0, 300, 407, 1);
        checkOutput("hit_below_out", 32'(paddle), 0);

        // Back into LOST; paddle must blank even over its own pixels.
        applyStimulus(0, 1, 0, 0, 252);
        applyStimulus(0, 1, 47, 399, 1);
        checkOutput("lost_again", 32'(state_dbg), 2);
        applyStimulus(0, 0, 47, 399, 1);
        checkOutput("lost_blank", 32'(paddle), 0);

        // Reset during the LOST hold.
        applyStimulus(0, 1, 0, 0, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst_lost_state", 32'(state_dbg), 0);
        checkOutput("rst_lost_col", 32'(paddle_col), 300);
        reset = 1'b0;

        pb_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) pb_r = ~pb_r;
            reset = ($urandom_range(0, 499) == 0);
            applyStimulus(pb_r, ($urandom_range(0, 2) == 0), m_col - 4 + int'($urandom_range(0, 15)),
                          m_row - 4 + int'($urandom_range(0, 15)), 1);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
